bomb_scheduler: RTL and testbench
=================================

// Module: bomb_scheduler
// PURPOSE
//  Owns the bomb slots for the player sprite. Takes the player's bomb request and pixel position,
//  snaps the position to the tile grid and gives it a free slot. Counts each slot's fuse and blast
//  time in frames. Drives the already_placed feedback back to the player-movement block.
//  Sits between the player-movement block and the bomb/explosion drawing and collision logic.
// PARAMETERS
//  NUM_BOMBS     2    number of bomb slots (1..4)
//  GRID          32   tile size in pixels (power of 2)
//  FUSE_FRAMES   90   frames from placement to explosion (>=1)
//  BLAST_FRAMES  30   frames the explosion stays active (>=1)
//  BLAST_CELLS   2    explosion reach in tiles, along the bomb's row and column
// PORTS
//  clk             in   1             system clock
//  reset           in   1             synchronous, active-high reset
//  startOfFrame    in   1             one-cycle pulse per frame
//  place_bomb      in   1             bomb key, level
//  player_x        in   11 signed     player top-left X, pixels
//  player_y        in   11 signed     player top-left Y, pixels
//  already_placed  out  1             registered; 1 = no free slot
//  bomb_armed      out  NUM_BOMBS     slot i is in ARMED
//  bomb_exploding  out  NUM_BOMBS     slot i is in EXPLODE
//  bomb_x          out  11*NUM_BOMBS  snapped X of slot i at bits [11i+10:11i]
//  bomb_y          out  11*NUM_BOMBS  snapped Y of slot i, same packing
//  explode_pulse   out  1             one cycle on any ARMED->EXPLODE transition
// BEHAVIOUR
//  - Reset: all slots IDLE, counters 0, every output 0. The edge register prev_key is set to 1, so a
//    key held through reset places nothing. Reset mid-fuse or mid-blast drops every slot at once.
//  - Request: req = place_bomb & ~prev_key (rising edge); prev_key <= place_bomb every cycle.
//  - Snap: cx = player_x & ~(GRID-1), cy = player_y & ~(GRID-1).
//  - A request is rejected with no state change if any of these holds:
//    player_x or player_y is negative; no slot is IDLE; a non-IDLE slot already holds (cx,cy).
//  - Allocation: the lowest-index IDLE slot, judged on the current-cycle state.
//    A request at cycle N shows on bomb_armed/bomb_x/bomb_y at cycle N+1. The fuse counter loads FUSE_FRAMES.
//  - Per-slot state machine (IDLE -> ARMED -> EXPLODE -> IDLE), one counter per slot:
//    IDLE    -> ARMED     on allocation.
//    ARMED   -> EXPLODE   on startOfFrame with cnt==1. Load BLAST_FRAMES; raise explode_pulse next cycle.
//                         Otherwise decrement cnt on each startOfFrame.
//    EXPLODE -> IDLE      on startOfFrame with cnt==1. Clear bomb_x/bomb_y to 0.
//                         Otherwise decrement cnt on each startOfFrame.
//  - Simultaneous events:
//    Allocation in the same cycle as startOfFrame: load FUSE_FRAMES, no decrement that cycle.
//    Slot going EXPLODE->IDLE in the same cycle as a request: not allocatable until the next cycle.
//    Several slots reaching expiry on one startOfFrame: all transition together; explode_pulse is a single cycle.
//  - already_placed is registered: 1 on the cycle after all slots become non-IDLE, and
//    0 on the cycle after any slot returns to IDLE.
//  - Counters are unsigned, wide enough for max(FUSE_FRAMES,BLAST_FRAMES). They never wrap below 1.
// CONFIGURATION
//  CHAIN_REACTION_EN defined:
//    - On startOfFrame, an ARMED slot goes to EXPLODE that same frame if an EXPLODE slot is in its row
//      or column within BLAST_CELLS*GRID pixels. The EXPLODE slot's state is taken before this startOfFrame.
//    - The chained slot loads BLAST_FRAMES and raises explode_pulse.
//    - The chain spreads one hop per frame.
//  CHAIN_REACTION_EN undefined:
//    - Slots are fully independent; only their own fuses trigger them.
// TESTING
//  1. Reset, key held high, then release and press at (70,100):
//     nothing placed while the key stays held; after the press, slot0 armed at (64,96) on the next cycle.
//  2. FUSE_FRAMES=3, BLAST_FRAMES=2, place at frame 0:
//     bomb_exploding set after the 3rd startOfFrame, with a 1-cycle explode_pulse;
//     IDLE and coordinates 0 after the 5th startOfFrame.
//  3. NUM_BOMBS=2, presses at (0,0), (64,0), (128,0):
//     slots 0 and 1 armed; already_placed=1; third press ignored.
//  4. Two presses at (40,40) then (50,50) (same tile): only slot0 allocated.
//  5. Press at (-5,40): rejected; all outputs stay 0.
//  6. CHAIN_REACTION_EN, GRID=32, BLAST_CELLS=2:
//     slot0 at (64,64) explodes while slot1 at (128,64) is armed → slot1 enters EXPLODE on the next startOfFrame.
//     Without the macro, slot1 keeps its own fuse.

Source files
------------

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - bomb slot allocation, fuse and blast timing for the player sprite
//
// Purpose: takes the player's bomb key and pixel position, snaps the position to the
// tile grid, hands the bomb to the lowest free slot and runs each slot through
// IDLE -> ARMED -> EXPLODE -> IDLE, counting fuse and blast time in frames.
// Optional feature macro: CHAIN_REACTION_EN (an exploding slot sets off armed slots
// in its row/column within BLAST_CELLS tiles, one hop per frame).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   startOfFrame    one-cycle pulse per frame
//   place_bomb      bomb key (level)
//   player_x/y      signed player top-left position in pixels
//   already_placed  registered, 1 = no free slot
//   bomb_armed      per-slot ARMED flag
//   bomb_exploding  per-slot EXPLODE flag
//   bomb_x/bomb_y   per-slot snapped coordinates, 11 bits per slot
//   explode_pulse   one cycle after any ARMED->EXPLODE transition
module bomb_scheduler #(
    parameter int NUM_BOMBS    = 2,
    parameter int GRID         = 32,
    parameter int FUSE_FRAMES  = 90,
    parameter int BLAST_FRAMES = 30,
    parameter int BLAST_CELLS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      place_bomb,
    input  logic signed [10:0]        player_x,
    input  logic signed [10:0]        player_y,
    output logic                      already_placed,
    output logic [NUM_BOMBS-1:0]      bomb_armed,
    output logic [NUM_BOMBS-1:0]      bomb_exploding,
    output logic [11*NUM_BOMBS-1:0]   bomb_x,
    output logic [11*NUM_BOMBS-1:0]   bomb_y,
    output logic                      explode_pulse
);

`ifdef CHAIN_REACTION_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    localparam int          MAXF      = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int          CW        = $clog2(MAXF + 1);
    localparam logic [10:0] SNAP_MASK = ~11'(GRID - 1);
    localparam logic [11:0] REACH     = 12'(BLAST_CELLS * GRID);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EXPLODE} slot_state_t;

    slot_state_t       state     [NUM_BOMBS];
    slot_state_t       state_nxt [NUM_BOMBS];
    logic [CW-1:0]     cnt       [NUM_BOMBS];
    logic [CW-1:0]     cnt_nxt   [NUM_BOMBS];
    logic [10:0]       bx        [NUM_BOMBS];
    logic [10:0]       bx_nxt    [NUM_BOMBS];
    logic [10:0]       by        [NUM_BOMBS];
    logic [10:0]       by_nxt    [NUM_BOMBS];
    logic              prev_key;

    logic                 req, neg, dup, any_idle, grant, pulse_nxt;
    logic [10:0]          cx, cy;
    logic [NUM_BOMBS-1:0] chain_hit;

    // Coordinates are never negative once stored, so a 12-bit difference is exact.
    function automatic logic axis_near(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[11]) d = -d;
        return d <= REACH;
    endfunction

    function automatic logic in_reach(input logic [10:0] ax, input logic [10:0] ay,
                                      input logic [10:0] ex, input logic [10:0] ey);
        return ((ay == ey) && axis_near(ax, ex)) || ((ax == ex) && axis_near(ay, ey));
    endfunction

    always_comb begin
        req       = place_bomb & ~prev_key;
        cx        = player_x & SNAP_MASK;
        cy        = player_y & SNAP_MASK;
        neg       = player_x[10] | player_y[10];
        any_idle  = 1'b0;
        dup       = 1'b0;
        chain_hit = '0;
        pulse_nxt = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (state[i] == S_IDLE) any_idle = 1'b1;
            else if (bx[i] == cx && by[i] == cy) dup = 1'b1;
        end
        // Chain source is judged on the registered state, so the chain advances one hop per frame.
        for (int i = 0; i < NUM_BOMBS; i++) begin
            for (int j = 0; j < NUM_BOMBS; j++) begin
                if (CHAIN_EN && state[i] == S_ARMED && state[j] == S_EXPLODE &&
                    in_reach(bx[i], by[i], bx[j], by[j]))
                    chain_hit[i] = 1'b1;
            end
        end
        grant = req & ~neg & ~dup;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            bx_nxt[i]    = bx[i];
            by_nxt[i]    = by[i];
            case (state[i])
                S_IDLE: begin
                    // Loop order gives the lowest-index idle slot; grant is consumed once.
                    if (grant) begin
                        state_nxt[i] = S_ARMED;
                        cnt_nxt[i]   = CW'(FUSE_FRAMES);
                        bx_nxt[i]    = cx;
                        by_nxt[i]    = cy;
                        grant        = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (startOfFrame) begin
                        if (cnt[i] == CW'(1) || chain_hit[i]) begin
                            state_nxt[i] = S_EXPLODE;
                            cnt_nxt[i]   = CW'(BLAST_FRAMES);
                            pulse_nxt    = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] - CW'(1);
                        end
                    end
                end
                S_EXPLODE: begin
                    if (startOfFrame) begin
                        if (cnt[i] == CW'(1)) begin
                            state_nxt[i] = S_IDLE;
                            bx_nxt[i]    = '0;
                            by_nxt[i]    = '0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - CW'(1);
                        end
                    end
                end
                default: state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_key       <= 1'b1;
            already_placed <= 1'b0;
            explode_pulse  <= 1'b0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
                bx[i]    <= '0;
                by[i]    <= '0;
            end
        end else begin
            prev_key       <= place_bomb;
            already_placed <= ~any_idle;
            explode_pulse  <= pulse_nxt;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                bx[i]    <= bx_nxt[i];
                by[i]    <= by_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_out
        assign bomb_armed[g]         = (state[g] == S_ARMED);
        assign bomb_exploding[g]     = (state[g] == S_EXPLODE);
        assign bomb_x[11*g +: 11]    = bx[g];
        assign bomb_y[11*g +: 11]    = by[g];
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - self-checking bench for bomb_scheduler
module tb_bomb_scheduler;
    localparam int NB    = 2;
    localparam int G     = 32;
    localparam int FUSE  = 3;
    localparam int BLAST = 2;
    localparam int BC    = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 startOfFrame = 1'b0;
    logic                 place_bomb = 1'b0;
    logic signed [10:0]   player_x = '0;
    logic signed [10:0]   player_y = '0;
    logic                 already_placed;
    logic [NB-1:0]        bomb_armed, bomb_exploding;
    logic [11*NB-1:0]     bomb_x, bomb_y;
    logic                 explode_pulse;

    bomb_scheduler #(.NUM_BOMBS(NB), .GRID(G), .FUSE_FRAMES(FUSE),
                     .BLAST_FRAMES(BLAST), .BLAST_CELLS(BC)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .place_bomb(place_bomb),
        .player_x(player_x), .player_y(player_y), .already_placed(already_placed),
        .bomb_armed(bomb_armed), .bomb_exploding(bomb_exploding),
        .bomb_x(bomb_x), .bomb_y(bomb_y), .explode_pulse(explode_pulse));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 fuse burning, 2 blast showing; frames_left counts remaining frames.
    int m_phase [NB];
    int m_left  [NB];
    int m_x     [NB];
    int m_y     [NB];
    bit m_prev, m_full, m_pulse;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit near(input int ax, input int ay, input int ex, input int ey);
        return (ay == ey && iabs(ax - ex) <= BC * G) || (ax == ex && iabs(ay - ey) <= BC * G);
    endfunction

    task automatic model_step();
        int ph [NB];
        int lf [NB];
        int xx [NB];
        int yy [NB];
        bit chain [NB];
        bit req, ok;
        int px, py, cx, cy, slot;
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_phase[i] = 0; m_left[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_prev = 1'b1; m_full = 1'b0; m_pulse = 1'b0;
            return;
        end
        req    = place_bomb && !m_prev;
        m_prev = place_bomb;
        for (int i = 0; i < NB; i++) begin
            ph[i] = m_phase[i]; lf[i] = m_left[i]; xx[i] = m_x[i]; yy[i] = m_y[i];
            chain[i] = 1'b0;
`ifdef CHAIN_REACTION_EN
            for (int j = 0; j < NB; j++)
                if (m_phase[i] == 1 && m_phase[j] == 2 && near(m_x[i], m_y[i], m_x[j], m_y[j]))
                    chain[i] = 1'b1;
`endif
        end
        m_pulse = 1'b0;
        if (startOfFrame) begin
            for (int i = 0; i < NB; i++) begin
                if (m_phase[i] == 1) begin
                    if (m_left[i] == 1 || chain[i]) begin
                        ph[i] = 2; lf[i] = BLAST; m_pulse = 1'b1;
                    end else lf[i] = m_left[i] - 1;
                end else if (m_phase[i] == 2) begin
                    if (m_left[i] == 1) begin
                        ph[i] = 0; xx[i] = 0; yy[i] = 0;
                    end else lf[i] = m_left[i] - 1;
                end
            end
        end
        px = int'(player_x);
        py = int'(player_y);
        if (req && px >= 0 && py >= 0) begin
            cx = (px / G) * G;
            cy = (py / G) * G;
            ok = 1'b1;
            slot = -1;
            for (int i = 0; i < NB; i++) begin
                if (m_phase[i] != 0 && m_x[i] == cx && m_y[i] == cy) ok = 1'b0;
                if (m_phase[i] == 0 && slot < 0) slot = i;
            end
            if (ok && slot >= 0) begin
                ph[slot] = 1; lf[slot] = FUSE; xx[slot] = cx; yy[slot] = cy;
            end
        end
        m_full = 1'b1;
        for (int i = 0; i < NB; i++) if (m_phase[i] == 0) m_full = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_phase[i] = ph[i]; m_left[i] = lf[i]; m_x[i] = xx[i]; m_y[i] = yy[i];
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        logic [NB-1:0]    ea, ee;
        logic [11*NB-1:0] ex, ey;
        if (check_en) begin
            for (int i = 0; i < NB; i++) begin
                ea[i] = (m_phase[i] == 1);
                ee[i] = (m_phase[i] == 2);
                ex[11*i +: 11] = 11'(m_x[i]);
                ey[11*i +: 11] = 11'(m_y[i]);
            end
            chk("model_armed", 32'(bomb_armed), 32'(ea));
            chk("model_exploding", 32'(bomb_exploding), 32'(ee));
            chk("model_x", 32'(bomb_x), 32'(ex));
            chk("model_y", 32'(bomb_y), 32'(ey));
            chk("model_already_placed", 32'(already_placed), 32'(m_full));
            chk("model_explode_pulse", 32'(explode_pulse), 32'(m_pulse));
        end
    end

    task automatic cyc(input bit s, input bit p, input int x, input int y);
        @(negedge clk);
        startOfFrame = s;
        place_bomb   = p;
        player_x     = x[10:0];
        player_y     = y[10:0];
    endtask

    task automatic idle(); cyc(0, 0, 0, 0); endtask
    task automatic press(input int x, input int y); cyc(0, 1, x, y); cyc(0, 0, x, y); endtask
    task automatic frame(); cyc(1, 0, 0, 0); idle(); endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; startOfFrame = 1'b0; place_bomb = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    initial begin
        // 1: key held through reset places nothing; press after release snaps (70,100)
        reset = 1'b1; place_bomb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        chk("reset_armed", 32'(bomb_armed), 32'd0);
        chk("reset_already_placed", 32'(already_placed), 32'd0);
        reset = 1'b0;
        repeat (3) cyc(0, 1, 70, 100);
        chk("held_key_no_place", 32'(bomb_armed), 32'd0);
        idle();
        press(70, 100);
        chk("t1_armed", 32'(bomb_armed), 32'h1);
        chk("t1_x", 32'(bomb_x[10:0]), 32'd64);
        chk("t1_y", 32'(bomb_y[10:0]), 32'd96);

        // 2: fuse of 3 frames, blast of 2 frames
        frame(); frame();
        chk("t2_not_yet", 32'(bomb_exploding), 32'd0);
        cyc(1, 0, 0, 0); idle();
        chk("t2_exploding", 32'(bomb_exploding), 32'h1);
        chk("t2_pulse", 32'(explode_pulse), 32'd1);
        idle();
        chk("t2_pulse_one_cycle", 32'(explode_pulse), 32'd0);
        frame(); frame();
        chk("t2_idle", 32'({bomb_armed, bomb_exploding}), 32'd0);
        chk("t2_x_cleared", 32'(bomb_x), 32'd0);

        // 3: two slots fill, third press ignored; expiry alongside a request
        press(0, 0); press(64, 0); press(128, 0); idle();
        chk("t3_armed", 32'(bomb_armed), 32'h3);
        chk("t3_already_placed", 32'(already_placed), 32'd1);
        chk("t3_x1", 32'(bomb_x[21:11]), 32'd64);
        frame(); frame(); frame();
        chk("t3_both_exploding", 32'(bomb_exploding), 32'h3);
        frame();
        cyc(1, 1, 192, 0); idle();
        chk("t3_expiry_req_rejected", 32'({bomb_armed, bomb_exploding}), 32'd0);
        chk("t3_ap_lags", 32'(already_placed), 32'd1);
        idle();
        chk("t3_ap_clears", 32'(already_placed), 32'd0);
        press(192, 0);
        chk("t3_realloc_x", 32'(bomb_x[10:0]), 32'd192);
        do_reset();
        chk("mid_fuse_reset", 32'({bomb_armed, bomb_exploding, bomb_x}), 32'd0);

        // 4: same tile twice
        press(40, 40); press(50, 50);
        chk("t4_same_tile", 32'(bomb_armed), 32'h1);
        chk("t4_x", 32'(bomb_x[10:0]), 32'd32);
        do_reset();

        // 5: negative position rejected
        press(-5, 40);
        chk("t5_neg_rejected", 32'({bomb_armed, bomb_x, bomb_y}), 32'd0);
        press(40, -1);
        chk("t5_neg_y_rejected", 32'(bomb_armed), 32'd0);

        // 6: chain reaction along a row
        press(64, 64);
        frame(); frame();
        press(128, 64);
        frame();
        chk("t6_slot0_explodes", 32'(bomb_exploding), 32'h1);
        frame();
`ifdef CHAIN_REACTION_EN
        chk("t6_chain", 32'(bomb_exploding), 32'h3);
`else
        chk("t6_no_chain", 32'(bomb_exploding), 32'h1);
`endif
        repeat (4) frame();
        chk("t6_all_idle", 32'({bomb_armed, bomb_exploding}), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
